// File: rtl/multi_digit_7seg.sv
// Binary to multi-digit 7-segment converter: serial double-dabble conversion,
// leading-zero blanking, overflow dashes, and a free-running digit scanner.
module multi_digit_7seg #(
    parameter int DIGITS   = 4,
    parameter int WIDTH    = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      binary,
    input  logic                  blank_zeros,
    output logic                  busy,
    output logic                  done,
    output logic [7*DIGITS-1:0]   display,
    output logic [6:0]            scan_seg,
    output logic [DIGITS-1:0]     scan_an
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SCW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [31:0] max_value(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) p = p * 32'd10;
        return p - 32'd1;
    endfunction

    localparam logic [31:0] MAX_VAL = max_value(DIGITS);

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_FINISH  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_shift;
    logic [4*DIGITS-1:0]  r_bcd;
    logic [4*DIGITS-1:0]  w_bcd_adj;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic                 r_blank;
    logic                 r_over;
    logic                 w_capture;
    logic                 w_step;
    logic                 w_finish;
    logic                 w_last;
    logic                 w_seen;
    logic [7*DIGITS-1:0]  w_display_new;
    logic [6:0]           w_dig_code   [DIGITS];
    logic [6:0]           w_disp_slice [DIGITS];
    logic [SCW-1:0]       r_scan_cnt;
    logic [IDW-1:0]       r_index;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        w_last       = (r_bit_cnt == CNT_W'(WIDTH - 1));
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_capture    = 1'b1;
                    w_state_next = S_CONVERT;
                end
            end
            S_CONVERT: begin
                w_step = 1'b1;
                if (w_last) w_state_next = S_FINISH;
            end
            S_FINISH: begin
                w_finish     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                          (r_bcd[4*gi +: 4] + 4'd3) : r_bcd[4*gi +: 4];
            assign w_dig_code[gi]   = seg_code(r_bcd[4*gi +: 4]);
            assign w_disp_slice[gi] = display[7*gi +: 7];
        end
    endgenerate

    // Walk from the top digit down; a digit is blanked only while no non-zero digit has been seen.
    always_comb begin
        w_display_new = '1;
        w_seen        = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (r_bcd[4*k +: 4] != 4'd0) w_seen = 1'b1;
            if (r_over)
                w_display_new[7*k +: 7] = SEG_DASH;
            else if (r_blank && !w_seen && (k != 0))
                w_display_new[7*k +: 7] = SEG_BLANK;
            else
                w_display_new[7*k +: 7] = w_dig_code[k];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shift   <= '0;
            r_bcd     <= '0;
            r_bit_cnt <= '0;
            r_blank   <= 1'b0;
            r_over    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            display   <= '1;
        end else begin
            done <= w_finish;
            busy <= (w_state_next != S_IDLE);
            if (w_capture) begin
                r_shift   <= binary;
                r_bcd     <= '0;
                r_bit_cnt <= '0;
                r_blank   <= blank_zeros;
                r_over    <= (32'(binary) > MAX_VAL);
            end
            if (w_step) begin
                r_bcd     <= {w_bcd_adj[4*DIGITS-2:0], r_shift[WIDTH-1]};
                r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_finish) display <= w_display_new;
        end
    end

    // Scanner runs regardless of conversion activity.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scan_cnt <= '0;
            r_index    <= '0;
            scan_an    <= ~DIGITS'(1);
            scan_seg   <= SEG_BLANK;
        end else begin
            if (r_scan_cnt == SCW'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_index    <= (r_index == IDW'(DIGITS - 1)) ? '0 : r_index + 1'b1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            scan_an  <= ~(DIGITS'(1) << r_index);
            scan_seg <= w_disp_slice[r_index];
        end
    end

endmodule
